// File: rtl/spi_reg_ctrl_if.sv
// Register-file and spi_slave buffer bus between spi_reg_ctrl (master side)
// and the RTC register file / spi_slave (slave side).
interface spi_reg_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] rx_data;
    logic [WIDTH-1:0] tx_data;
    logic             tx_wr;
    logic [WIDTH-2:0] reg_addr;
    logic [WIDTH-1:0] reg_wdata;
    logic             reg_we;
    logic             reg_re;
    logic [WIDTH-1:0] reg_rdata;

    modport master (
        input  rx_data,
        input  reg_rdata,
        output tx_data,
        output tx_wr,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re
    );

    modport slave (
        output rx_data,
        output reg_rdata,
        input  tx_data,
        input  tx_wr,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI transaction controller: frames bytes from the synchronised SPI pins,
// decodes {rw, addr} and drives register-file strobes with address auto-increment.
module spi_reg_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sclk,
    input  logic           ss,
    spi_reg_ctrl_if.master bus,
    output logic           busy
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RFETCH,
        RLOAD,
        RDATA
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic                   sclk_prev;
    logic                   ss_prev;
    logic                   sclk_s;
    logic                   ss_s;
    logic                   sclk_rise;
    logic                   ss_fall;
    logic                   ss_rise;

    logic [CW-1:0]          bit_cnt;
    logic                   byte_stb;
    logic [WIDTH-2:0]       addr;
    logic [WIDTH-1:0]       tx_data_q;
    logic [WIDTH-1:0]       wdata_q;
    logic                   we_q;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev && !ss_s;
    assign ss_fall   = !ss_s && ss_prev;
    assign ss_rise   = ss_s && !ss_prev;

    // ss synchroniser clears to 0, so after reset a select that is already
    // low never looks like a fall: the master must deselect and reselect.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            byte_stb <= 1'b0;
        end else begin
            byte_stb <= 1'b0;
            if (ss_rise || ss_fall) begin
                bit_cnt <= '0;
            end else if (sclk_rise) begin
                if (bit_cnt == CW'(WIDTH - 1)) begin
                    bit_cnt  <= '0;
                    byte_stb <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A read strobe already issued in RFETCH or RLOAD still fires even if
    // ss rises in that cycle; the deselect only redirects the next state.
    always_comb begin
        state_next = state;
        bus.reg_re = 1'b0;
        bus.tx_wr  = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) state_next = CMD;
            end
            CMD: begin
                if (ss_rise)       state_next = IDLE;
                else if (byte_stb) state_next = bus.rx_data[WIDTH-1] ? RFETCH : WDATA;
            end
            WDATA: begin
                if (ss_rise) state_next = IDLE;
            end
            RFETCH: begin
                bus.reg_re = 1'b1;
                state_next = ss_rise ? IDLE : RLOAD;
            end
            RLOAD: begin
                bus.tx_wr  = 1'b1;
                state_next = ss_rise ? IDLE : RDATA;
            end
            RDATA: begin
                if (ss_rise)       state_next = IDLE;
                else if (byte_stb) state_next = RFETCH;
            end
            default: state_next = IDLE;
        endcase
    end

    // The write strobe is registered so a byte_stb that coincides with a
    // deselect still produces its write one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            tx_data_q <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
        end else begin
            we_q <= (state == WDATA) && byte_stb;
            if ((state == WDATA) && byte_stb) wdata_q <= bus.rx_data;
            if ((state == CMD) && byte_stb) begin
                addr <= bus.rx_data[WIDTH-2:0];
            end else if (we_q || (state == RLOAD)) begin
                addr <= addr + 1'b1;
            end
            if (state == RLOAD) tx_data_q <= bus.reg_rdata;
        end
    end

    // tx_data is transparent during RLOAD so spi_slave sees the fresh read
    // data in the same cycle as tx_wr.
    assign bus.tx_data   = (state == RLOAD) ? bus.reg_rdata : tx_data_q;
    assign bus.reg_addr  = addr;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_we    = we_q;
    assign busy          = (state != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Testbench for spi_reg_ctrl: SPI master + register-file/spi_slave models,
// table-driven transactions checked through strobe scoreboards.
module tb_spi_reg_ctrl;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int HALF  = 8;

    logic clk = 1'b0;
    logic rst;
    logic sclk;
    logic ss;
    logic busy;

    spi_reg_ctrl_if #(.WIDTH(WIDTH)) bus ();

    spi_reg_ctrl #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sclk(sclk),
        .ss  (ss),
        .bus (bus),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [7:0]      cmd;
        int              n;
        logic [3:0][7:0] d;
        int              ns;
        logic [3:0][6:0] exp_addr;
        logic [3:0][7:0] exp_val;
    } vec_t;

    vec_t vecs[6];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_bit_cyc = 0;
    int we_cnt = 0;
    int re_cnt = 0;
    int tx_cnt = 0;

    logic [7:0]  tx_buf;
    logic [7:0]  miso_shift;
    logic [14:0] exp_wr_q[$];
    logic [6:0]  exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic        prev_we = 1'b0;
    logic        prev_re = 1'b0;
    logic        prev_tx = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] all_outputs();
        return {5'b0, bus.tx_data, bus.tx_wr, bus.reg_addr, bus.reg_wdata,
                bus.reg_we, bus.reg_re, busy};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Register file returns a^0xFF one cycle after reg_re
    always @(posedge clk) begin
        if (bus.reg_re) bus.reg_rdata <= {1'b0, bus.reg_addr} ^ 8'hFF;
    end

    // spi_slave tx buffer model
    always @(posedge clk) begin
        if (rst)            tx_buf <= 8'h00;
        else if (bus.tx_wr) tx_buf <= bus.tx_data;
    end

    // Strobe monitor and scoreboard pop
    always @(negedge clk) begin
        if (bus.reg_we || bus.reg_re || bus.tx_wr) begin
            check("strobe_exclusive", $countones({bus.reg_we, bus.reg_re, bus.tx_wr}), 1);
            check("strobe_width", {29'b0, bus.reg_we & prev_we, bus.reg_re & prev_re,
                                   bus.tx_wr & prev_tx}, 0);
        end
        if (bus.reg_we) begin
            we_cnt++;
            check("we_pending", 32'(exp_wr_q.size() > 0), 1);
            if (exp_wr_q.size() > 0)
                check("write_addr_data", {17'b0, bus.reg_addr, bus.reg_wdata}, {17'b0, exp_wr_q.pop_front()});
        end
        if (bus.reg_re) begin
            re_cnt++;
            check("re_pending", 32'(exp_rd_q.size() > 0), 1);
            if (exp_rd_q.size() > 0)
                check("read_addr", {25'b0, bus.reg_addr}, {25'b0, exp_rd_q.pop_front()});
        end
        if (bus.tx_wr) begin
            tx_cnt++;
            check("tx_pending", 32'(exp_tx_q.size() > 0), 1);
            if (exp_tx_q.size() > 0)
                check("tx_data", {24'b0, bus.tx_data}, {24'b0, exp_tx_q.pop_front()});
            check("tx_after_re", {31'b0, prev_re}, 1);
            check("tx_latency", cyc - last_bit_cyc, SYNC + 3);
        end
        prev_we = bus.reg_we;
        prev_re = bus.reg_re;
        prev_tx = bus.tx_wr;
    end

    // SPI mode-0 master; rx_data is updated as spi_slave would at the last bit
    task automatic send_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
        got = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            if (k == 0) miso_shift = tx_buf;
            repeat (HALF) @(negedge clk);
            if (nbits == 8 && k == 7) begin
                bus.rx_data  = b;
                last_bit_cyc = cyc;
            end
            sclk = 1'b1;
            got[7-k]   = miso_shift[7];
            miso_shift = miso_shift << 1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic mk(input int i, input string nm, input logic [7:0] cmd, input int n,
                      input logic [31:0] d, input int ns, input logic [27:0] ea,
                      input logic [31:0] ev);
        vecs[i].name     = nm;
        vecs[i].cmd      = cmd;
        vecs[i].n        = n;
        vecs[i].d        = d;
        vecs[i].ns       = ns;
        vecs[i].exp_addr = ea;
        vecs[i].exp_val  = ev;
    endtask

    task automatic applyStimulus(input vec_t v, output logic [3:0][7:0] got);
        logic [7:0] b;
        got = '0;
        for (int j = 0; j < v.ns; j++) begin
            if (v.cmd[7]) begin
                exp_rd_q.push_back(v.exp_addr[j]);
                exp_tx_q.push_back(v.exp_val[j]);
            end else begin
                exp_wr_q.push_back({v.exp_addr[j], v.exp_val[j]});
            end
        end
        ss = 1'b0;
        send_bits(v.cmd, 8, b);
        check({v.name, "_busy_active"}, {31'b0, busy}, 1);
        for (int j = 0; j < v.n; j++) begin
            send_bits(v.d[j], 8, b);
            got[j] = b;
        end
        repeat (20) @(negedge clk);
        ss = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic checkOutput(input vec_t v, input logic [3:0][7:0] got);
        check({v.name, "_we_missing"}, exp_wr_q.size(), 0);
        check({v.name, "_re_missing"}, exp_rd_q.size(), 0);
        check({v.name, "_tx_missing"}, exp_tx_q.size(), 0);
        check({v.name, "_busy_idle"}, {31'b0, busy}, 0);
        if (v.cmd[7]) begin
            for (int j = 0; j < v.n; j++)
                check({v.name, "_miso"}, {24'b0, got[j]}, {24'b0, v.exp_val[j]});
        end
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_tx_q.delete();
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0][7:0] got;
        logic [7:0]      g;
        int              w0;

        mk(0, "single_write",      8'h05, 1, 32'h000000A5, 1, {7'h00, 7'h00, 7'h00, 7'h05}, 32'h000000A5);
        mk(1, "burst_wrap",        8'h7E, 3, 32'h00332211, 3, {7'h00, 7'h00, 7'h7F, 7'h7E}, 32'h00332211);
        mk(2, "burst_read",        8'h83, 2, 32'h00000000, 3, {7'h00, 7'h05, 7'h04, 7'h03}, 32'h00FAFBFC);
        mk(3, "single_read",       8'h80, 0, 32'h00000000, 1, {7'h00, 7'h00, 7'h00, 7'h00}, 32'h000000FF);
        mk(4, "write_after_abort", 8'h10, 1, 32'h0000005A, 1, {7'h00, 7'h00, 7'h00, 7'h10}, 32'h0000005A);
        mk(5, "write_after_reset", 8'h21, 1, 32'h0000003C, 1, {7'h00, 7'h00, 7'h00, 7'h21}, 32'h0000003C);

        rst         = 1'b1;
        ss          = 1'b1;
        sclk        = 1'b0;
        bus.rx_data = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_state", all_outputs(), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_after_reset", {31'b0, busy}, 0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i], got);
            checkOutput(vecs[i], got);
        end

        // Abort: command byte then half a data byte, then deselect
        w0 = we_cnt;
        ss = 1'b0;
        send_bits(8'h10, 8, g);
        send_bits(8'hA5, 4, g);
        repeat (4) @(negedge clk);
        ss = 1'b1;
        repeat (12) @(negedge clk);
        check("abort_no_we", we_cnt - w0, 0);
        check("abort_busy", {31'b0, busy}, 0);
        applyStimulus(vecs[4], got);
        checkOutput(vecs[4], got);

        // Reset pulse during the third bit of a data byte
        w0 = we_cnt;
        ss = 1'b0;
        send_bits(8'h20, 8, g);
        send_bits(8'hC3, 2, g);
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reset_mid_outputs", all_outputs(), 0);
        repeat (HALF - 2) @(negedge clk);
        sclk = 1'b0;
        send_bits(8'h18, 5, g);
        repeat (10) @(negedge clk);
        check("reset_mid_no_we", we_cnt - w0, 0);
        check("reset_mid_busy", {31'b0, busy}, 0);
        ss = 1'b1;
        repeat (12) @(negedge clk);
        applyStimulus(vecs[5], got);
        checkOutput(vecs[5], got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
